multi_pulse_sync_rx: RTL and testbench

Destination-domain receiver for multi-channel toggle-encoded events crossing into `i_clock`. Each channel is synchronized through a parametrised flop chain and edge-detected into a single-cycle pulse. Events are also counted per channel and serialised through a round-robin arbiter onto one valid/ready event stream. A per-channel acknowledge toggle is returned to the source on consumption. It replaces single-channel pulse synchronizers wherever several sideband/LTSM events from one source domain land in the same clock.

---
 rtl/pulse_sync_pkg.sv | 25 ++
 rtl/toggle_sync_cell.sv | 35 +++
 rtl/multi_pulse_sync_rx.sv | 178 +++++++++++++++++
 tb/tb_multi_pulse_sync_rx.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sync_pkg.sv
// Shared definitions for the multi-channel toggle pulse receiver:
// minimum synchronizer depth, output-slot state encoding and the
// width/saturation helper functions used to size ports and counters.
package pulse_sync_pkg;

   // Fewer than two flops gives no metastability settling time at all.
   localparam int SYNC_STAGES_MIN = 2;

   // Occupancy of the single-entry event output slot.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // Width of a channel index; a single channel still needs one bit.
   function automatic int ch_idx_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // Largest value a cnt_w-bit pending counter may hold.
   function automatic int sat_max(input int cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

endpackage

// File: rtl/toggle_sync_cell.sv
// One channel of the receiver: brings an asynchronous toggle level into
// i_clock through a flop chain and converts each level change into a
// single-cycle edge flag.
module toggle_sync_cell
   import pulse_sync_pkg::*;
#(
   parameter int SYNC_STAGES = 3
) (
   input  logic i_clock,
   input  logic i_rst_n,
   input  logic i_toggle,
   output logic o_edge
);

   // Depth is clamped so a mis-set parameter can never remove settling time.
   localparam int S = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

   logic [S-1:0] r_sync;
   logic         r_last;

   // Shift the raw toggle through the chain and remember the previous settled level.
   always_ff @(posedge i_clock) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_last <= 1'b0;
      end else begin
         r_sync <= {r_sync[S-2:0], i_toggle};
         r_last <= r_sync[S-1];
      end
   end

   // A difference between the settled level and its previous value is one source event.
   assign o_edge = r_sync[S-1] ^ r_last;

endmodule

// File: rtl/multi_pulse_sync_rx.sv
// Destination-domain receiver for several toggle-encoded event channels.
// Each channel is synchronized and edge-detected into o_pulse; events are
// also counted per channel and served round-robin through a one-entry
// valid/ready slot. Every consumed event flips that channel's ack toggle,
// and a sticky overflow flag records events lost to a saturated counter.
module multi_pulse_sync_rx
   import pulse_sync_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int SYNC_STAGES = 3,
   parameter int CNT_W       = 3
) (
   input  logic                          i_clock,
   input  logic                          i_rst_n,
   input  logic [NUM_CH-1:0]             i_toggle,
   output logic [NUM_CH-1:0]             o_pulse,
   output logic                          o_evt_valid,
   output logic [ch_idx_w(NUM_CH)-1:0]   o_evt_ch,
   input  logic                          i_evt_ready,
   output logic [NUM_CH-1:0]             o_ack_toggle,
   output logic [NUM_CH-1:0]             o_overflow,
   input  logic                          i_clr_overflow
);

   localparam int               CH_W     = ch_idx_w(NUM_CH);
   localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(sat_max(CNT_W));

   // Index base+off folded back into 0..NUM_CH-1 (off is always < NUM_CH).
   function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_CH) begin
         s = s - NUM_CH;
      end
      return CH_W'(s);
   endfunction

   // ---- stage p0: per-channel synchronizers and edge detectors ----
   logic [NUM_CH-1:0] w_edge;

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_ch
         toggle_sync_cell #(
            .SYNC_STAGES (SYNC_STAGES)
         ) u_cell (
            .i_clock  (i_clock),
            .i_rst_n  (i_rst_n),
            .i_toggle (i_toggle[g]),
            .o_edge   (w_edge[g])
         );
      end
   endgenerate

   assign o_pulse = w_edge;

   // ---- stage p1: pending counters, arbiter, output slot ----
   logic [CNT_W-1:0]  r_pend [NUM_CH];
   logic [NUM_CH-1:0] w_pend_nz;
   logic [CH_W-1:0]   r_rr_ptr;
   logic [CH_W-1:0]   r_evt_ch;
   slot_state_e       r_slot_state;
   slot_state_e       w_slot_state;
   logic              w_load;
   logic              w_xfer;
   logic              w_found;
   logic [CH_W-1:0]   w_sel;
   logic [NUM_CH-1:0] w_dec;
   logic [NUM_CH-1:0] w_ovf_set;
   logic [NUM_CH-1:0] w_ack_flip;
   logic [NUM_CH-1:0] r_ack;
   logic [NUM_CH-1:0] r_overflow;

   // Flag channels with at least one registered pending event; new edges wait a cycle.
   always_comb begin
      w_pend_nz = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_pend_nz[c] = (r_pend[c] != '0);
      end
   end

   // Round-robin search: first pending channel at or after r_rr_ptr, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!w_found && w_pend_nz[wrap_idx(r_rr_ptr, k)]) begin
            w_found = 1'b1;
            w_sel   = wrap_idx(r_rr_ptr, k);
         end
      end
   end

   // Slot occupancy state register.
   always_ff @(posedge i_clock) begin
      if (!i_rst_n) begin
         r_slot_state <= SLOT_EMPTY;
      end else begin
         r_slot_state <= w_slot_state;
      end
   end

   // Slot next state: reload when empty or draining this cycle, empty if nothing is pending.
   always_comb begin
      w_slot_state = r_slot_state;
      w_load       = 1'b0;
      case (r_slot_state)
         SLOT_EMPTY: w_load = 1'b1;
         SLOT_FULL:  w_load = i_evt_ready;
         default:    w_load = 1'b1;
      endcase
      if (w_load) begin
         w_slot_state = w_found ? SLOT_FULL : SLOT_EMPTY;
      end
   end

   assign o_evt_valid = (r_slot_state == SLOT_FULL);
   assign o_evt_ch    = r_evt_ch;
   assign w_xfer      = o_evt_valid & i_evt_ready;

   // Channel consumed by this cycle's load, and counters that would exceed saturation.
   always_comb begin
      w_dec = '0;
      if (w_load && w_found) begin
         w_dec[w_sel] = 1'b1;
      end
      w_ovf_set = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_ovf_set[c] = w_edge[c] & ~w_dec[c] & (r_pend[c] == PEND_MAX);
      end
   end

   // Pending counters: a same-cycle edge and load cancel; saturation holds the value.
   always_ff @(posedge i_clock) begin
      if (!i_rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_pend[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_edge[c] && !w_dec[c] && !w_ovf_set[c]) begin
               r_pend[c] <= r_pend[c] + CNT_W'(1);
            end else if (w_dec[c] && !w_edge[c]) begin
               r_pend[c] <= r_pend[c] - CNT_W'(1);
            end
         end
      end
   end

   // Capture the selected channel and advance the round-robin pointer past it.
   always_ff @(posedge i_clock) begin
      if (!i_rst_n) begin
         r_evt_ch <= '0;
         r_rr_ptr <= '0;
      end else if (w_load && w_found) begin
         r_evt_ch <= w_sel;
         r_rr_ptr <= wrap_idx(w_sel, 1);
      end
   end

   // ---- stage p2: acknowledge toggles and overflow flags ----
   assign w_ack_flip = w_xfer ? (NUM_CH'(1) << r_evt_ch) : '0;

   // Flip the ack of each consumed channel; overflow is sticky and a new set beats clear.
   always_ff @(posedge i_clock) begin
      if (!i_rst_n) begin
         r_ack      <= '0;
         r_overflow <= '0;
      end else begin
         r_ack      <= r_ack ^ w_ack_flip;
         r_overflow <= (i_clr_overflow ? '0 : r_overflow) | w_ovf_set;
      end
   end

   assign o_ack_toggle = r_ack;
   assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_multi_pulse_sync_rx.sv
// Self-checking bench for multi_pulse_sync_rx (NUM_CH=4, SYNC_STAGES=3, CNT_W=2).
// A behavioural model (delayed input levels, integer event counts, a
// round-robin search with modulo arithmetic) predicts every output each cycle;
// directed scenarios additionally check fixed expected timings and orders.
module tb_multi_pulse_sync_rx;

   localparam int NCH  = 4;
   localparam int S    = 3;
   localparam int PMAX = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ready;
   logic       clr;
   logic [3:0] tog;
   logic [3:0] pulse;
   logic [3:0] ack;
   logic [3:0] ovf;
   logic       valid;
   logic [1:0] ch;

   always #5 clk = ~clk;

   multi_pulse_sync_rx #(
      .NUM_CH      (4),
      .SYNC_STAGES (3),
      .CNT_W       (2)
   ) dut (
      .i_clock        (clk),
      .i_rst_n        (rst_n),
      .i_toggle       (tog),
      .o_pulse        (pulse),
      .o_evt_valid    (valid),
      .o_evt_ch       (ch),
      .i_evt_ready    (ready),
      .o_ack_toggle   (ack),
      .o_overflow     (ovf),
      .i_clr_overflow (clr)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int         m_pend [NCH];
   logic [3:0] m_hist [S+1];
   bit         m_valid;
   int         m_ch;
   int         m_rr;
   logic [3:0] m_ack;
   logic [3:0] m_ovf;
   int         d_xfer [$];

   function automatic logic [14:0] dut_vec();
      return {pulse, valid, (valid ? ch : 2'b00), ack, ovf};
   endfunction

   function automatic logic [14:0] mdl_vec();
      logic [1:0] mc;
      mc = 2'(m_ch);
      return {m_hist[S-1] ^ m_hist[S], m_valid, (m_valid ? mc : 2'b00), m_ack, m_ovf};
   endfunction

   // Advance model and DUT by one clock; records DUT transfers as they happen.
   task automatic step();
      logic [3:0] e;
      logic [3:0] setv;
      bit         found;
      bit         load;
      bit         dec;
      int         sel;
      int         np [NCH];
      if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) d_xfer.push_back(int'(ch));
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) m_pend[c] = 0;
         for (int i = 0; i <= S; i++) m_hist[i] = 4'h0;
         m_valid = 0; m_ch = 0; m_rr = 0; m_ack = 4'h0; m_ovf = 4'h0;
      end else begin
         e     = m_hist[S-1] ^ m_hist[S];
         load  = !m_valid || ready;
         found = 0;
         sel   = 0;
         for (int k = 0; k < NCH; k++) begin
            if (!found && m_pend[(m_rr + k) % NCH] > 0) begin
               found = 1;
               sel   = (m_rr + k) % NCH;
            end
         end
         setv = 4'h0;
         for (int c = 0; c < NCH; c++) begin
            dec   = load && found && (sel == c);
            np[c] = m_pend[c];
            if (e[c] && !dec) begin
               if (m_pend[c] == PMAX) setv[c] = 1'b1;
               else np[c] = m_pend[c] + 1;
            end else if (dec && !e[c]) begin
               np[c] = m_pend[c] - 1;
            end
         end
         if (m_valid && ready) m_ack[m_ch] = ~m_ack[m_ch];
         m_ovf = (clr ? 4'h0 : m_ovf) | setv;
         if (load) begin
            m_valid = found;
            if (found) begin
               m_ch = sel;
               m_rr = (sel + 1) % NCH;
            end
         end
         for (int c = 0; c < NCH; c++) m_pend[c] = np[c];
         for (int i = S; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = tog;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; tog = 4'h0; ready = 1'b0; clr = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      d_xfer.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; tog = 4'h0; ready = 1'b0; clr = 1'b0;
      step();
      n_cmp++;
      if (dut_vec() !== 15'h0) begin
         n_bad++; $display("FAIL reset_outputs act=%h req=%h", dut_vec(), 15'h0);
      end
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         step();
         n_cmp++;
         if (dut_vec() !== mdl_vec()) begin
            n_bad++; $display("FAIL reset_idle cyc%0d act=%h req=%h", n, dut_vec(), mdl_vec());
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      ready = 1'b1;
      tog   = 4'b0100;
      step();
      for (int n = 0; n < 9; n++) begin
         n_cmp++;
         if (pulse[2] !== (n == 2)) begin
            n_bad++; $display("FAIL single_pulse cyc%0d act=%b req=%b", n, pulse[2], (n == 2));
         end
         n_cmp++;
         if (valid !== (n == 4) || (n == 4 && ch !== 2'd2)) begin
            n_bad++; $display("FAIL single_valid cyc%0d act=%b/%0d req=%b/2", n, valid, ch, (n == 4));
         end
         n_cmp++;
         if (ack[2] !== (n >= 5)) begin
            n_bad++; $display("FAIL single_ack cyc%0d act=%b req=%b", n, ack[2], (n >= 5));
         end
         n_cmp++;
         if (dut_vec() !== mdl_vec()) begin
            n_bad++; $display("FAIL single_model cyc%0d act=%h req=%h", n, dut_vec(), mdl_vec());
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tog[0] = ~tog[0];
         for (int n = 0; n < 4; n++) begin
            step();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
               n_bad++; $display("FAIL bp_model cyc%0d act=%h req=%h", i*4+n, dut_vec(), mdl_vec());
            end
         end
      end
      for (int n = 0; n < 6; n++) begin
         step();
         n_cmp++;
         if (valid !== 1'b1 || ch !== 2'd0) begin
            n_bad++; $display("FAIL bp_hold cyc%0d act=%b/%0d req=1/0", n, valid, ch);
         end
      end
      ready = 1'b1;
      for (int n = 0; n < 3; n++) step();
      n_cmp++;
      if (d_xfer.size() != 3) begin
         n_bad++; $display("FAIL bp_xfer_count act=%0d req=3", d_xfer.size());
      end
      n_cmp++;
      if (valid !== 1'b0 || ack[0] !== 1'b1) begin
         n_bad++; $display("FAIL bp_end act=valid%b ack%b req=valid0 ack1", valid, ack[0]);
      end
   endtask

   task automatic test_round_robin();
      int exp1 [4] = '{0, 1, 2, 3};
      int exp2 [2] = '{0, 3};
      do_reset();
      ready = 1'b1;
      tog   = 4'hF;
      for (int n = 0; n < 10; n++) begin
         step();
         n_cmp++;
         if (dut_vec() !== mdl_vec()) begin
            n_bad++; $display("FAIL rr_model cyc%0d act=%h req=%h", n, dut_vec(), mdl_vec());
         end
      end
      n_cmp++;
      if (d_xfer.size() != 4) begin
         n_bad++; $display("FAIL rr_count act=%0d req=4", d_xfer.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (d_xfer[i] != exp1[i]) begin
               n_bad++; $display("FAIL rr_order idx%0d act=%0d req=%0d", i, d_xfer[i], exp1[i]);
            end
         end
      end
      d_xfer.delete();
      tog = tog ^ 4'b1001;
      for (int n = 0; n < 10; n++) step();
      n_cmp++;
      if (d_xfer.size() != 2) begin
         n_bad++; $display("FAIL rr_pair_count act=%0d req=2", d_xfer.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (d_xfer[i] != exp2[i]) begin
               n_bad++; $display("FAIL rr_pair idx%0d act=%0d req=%0d", i, d_xfer[i], exp2[i]);
            end
         end
      end
   endtask

   task automatic test_overflow();
      bit seen;
      do_reset();
      // first event occupies the slot, three more saturate the counter, the fifth overflows
      for (int i = 0; i < 5; i++) begin
         tog[1] = ~tog[1];
         for (int n = 0; n < 4; n++) begin
            step();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
               n_bad++; $display("FAIL ovf_model cyc%0d act=%h req=%h", i*4+n, dut_vec(), mdl_vec());
            end
         end
      end
      step();
      n_cmp++;
      if (ovf !== 4'b0010) begin
         n_bad++; $display("FAIL ovf_set act=%b req=0010", ovf);
      end
      clr = 1'b1; step(); clr = 1'b0;
      n_cmp++;
      if (ovf !== 4'b0000) begin
         n_bad++; $display("FAIL ovf_clear act=%b req=0000", ovf);
      end
      tog[1] = ~tog[1];
      step();
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (pulse[1] === 1'b1) seen = 1;
         else step();
      end
      n_cmp++;
      if (!seen) begin
         n_bad++; $display("FAIL ovf_pulse_timeout act=0 req=1");
      end
      clr = 1'b1; step(); clr = 1'b0;
      n_cmp++;
      if (ovf !== 4'b0010) begin
         n_bad++; $display("FAIL ovf_collide act=%b req=0010", ovf);
      end
      d_xfer.delete();
      ready = 1'b1;
      for (int n = 0; n < 8; n++) step();
      n_cmp++;
      if (d_xfer.size() != 4) begin
         n_bad++; $display("FAIL ovf_drain act=%0d req=4", d_xfer.size());
      end
   endtask

   task automatic test_same_cycle();
      bit seen;
      do_reset();
      tog[3] = 1'b1;
      for (int n = 0; n < 6; n++) step();
      tog[3] = 1'b0;
      for (int n = 0; n < 6; n++) step();
      tog[3] = 1'b1;
      step();
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (pulse[3] === 1'b1) seen = 1;
         else step();
      end
      n_cmp++;
      if (!seen) begin
         n_bad++; $display("FAIL same_pulse_timeout act=0 req=1");
      end
      ready = 1'b1;
      step();
      n_cmp++;
      if (valid !== 1'b1 || ch !== 2'd3) begin
         n_bad++; $display("FAIL same_reload act=%b/%0d req=1/3", valid, ch);
      end
      for (int n = 0; n < 5; n++) begin
         step();
         n_cmp++;
         if (dut_vec() !== mdl_vec()) begin
            n_bad++; $display("FAIL same_model cyc%0d act=%h req=%h", n, dut_vec(), mdl_vec());
         end
      end
      n_cmp++;
      if (d_xfer.size() != 3) begin
         n_bad++; $display("FAIL same_count act=%0d req=3", d_xfer.size());
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      tog = 4'b0101;
      for (int n = 0; n < 5; n++) step();
      tog = 4'b0000;
      for (int n = 0; n < 3; n++) step();
      n_cmp++;
      if (valid !== 1'b1) begin
         n_bad++; $display("FAIL rmid_pre act=%b req=1", valid);
      end
      rst_n = 1'b0;
      step();
      n_cmp++;
      if (dut_vec() !== 15'h0) begin
         n_bad++; $display("FAIL rmid_outputs act=%h req=%h", dut_vec(), 15'h0);
      end
      step();
      rst_n = 1'b1;
      ready = 1'b1;
      for (int n = 0; n < 20; n++) begin
         step();
         n_cmp++;
         if (valid !== 1'b0 || pulse !== 4'h0) begin
            n_bad++; $display("FAIL rmid_quiet cyc%0d act=%b/%b req=0/0000", n, valid, pulse);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] flip;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         flip = 4'h0;
         for (int c = 0; c < NCH; c++) flip[c] = ($urandom_range(0, 5) == 0);
         tog   = tog ^ flip;
         ready = ((i / 60) % 3 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         clr   = ($urandom_range(0, 31) == 0);
         step();
         n_cmp++;
         if (dut_vec() !== mdl_vec()) begin
            n_bad++; $display("FAIL random cyc%0d act=%h req=%h", i, dut_vec(), mdl_vec());
         end
      end
      ready = 1'b1; clr = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         n_cmp++;
         if (dut_vec() !== mdl_vec()) begin
            n_bad++; $display("FAIL random_drain cyc%0d act=%h req=%h", i, dut_vec(), mdl_vec());
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; tog = 4'h0; ready = 1'b0; clr = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_round_robin();
      test_overflow();
      test_same_cycle();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
